// File: rtl/pe_pkg.sv
// pe_pkg: shared defaults, FSM encoding and width helpers for pe_kmac
package pe_pkg;
  localparam int DATA_BITS_DEF = 16;
  localparam int INTERNAL_BITS_DEF = 32;
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic int sum_bits(input int data_bits, input int taps);
    return 2 * data_bits + $clog2(taps);
  endfunction
endpackage

// File: rtl/pe_dot.sv
// pe_dot: registered per-tap signed products and their combinational tree sum
module pe_dot
  import pe_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int TAPS = 3
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         en,
  input  logic [TAPS-1:0][DATA_BITS-1:0]               f,
  input  logic [TAPS-1:0][DATA_BITS-1:0]               w,
  output logic signed [sum_bits(DATA_BITS, TAPS)-1:0]  sum
);
  localparam int PW = 2 * DATA_BITS;
  localparam int SW = sum_bits(DATA_BITS, TAPS);
  logic signed [PW-1:0] prod [TAPS];
  // capture one product per tap whenever a term is sampled
  always_ff @(posedge clk)
    for (int i = 0; i < TAPS; i++)
      if (rst) prod[i] <= '0;
      else if (en) prod[i] <= PW'(signed'(f[i])) * PW'(signed'(w[i]));
  // sign-extend and add all products of the term
  always_comb begin
    sum = '0;
    for (int i = 0; i < TAPS; i++) sum = sum + SW'(prod[i]);
  end
endmodule

// File: rtl/pe_kmac.sv
// pe_kmac: tapped dot-product MAC over windows; define PE_SATURATE_EN for result clamping and sticky ovf
module pe_kmac
  import pe_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int INTERNAL_BITS = INTERNAL_BITS_DEF,
  parameter int TAPS = 3,
  parameter int GUARD_BITS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            if_w,
  input  logic                            w_w,
  input  logic signed [DATA_BITS-1:0]     if_in,
  input  logic signed [DATA_BITS-1:0]     w_in,
  input  logic                            mac_en,
  input  logic                            mac_last,
  input  logic                            acc_clr,
  output logic signed [INTERNAL_BITS-1:0] result,
  output logic                            out_valid,
  output logic                            busy,
  output logic                            ovf
);
  localparam int SW = sum_bits(DATA_BITS, TAPS);
  localparam int AW = INTERNAL_BITS + GUARD_BITS;
  logic [TAPS-1:0][DATA_BITS-1:0] f_tap, w_tap;
  logic [TAPS:0][DATA_BITS-1:0] f_ext, w_ext;
  logic v1, l1, commit, ovr, ov;
  logic signed [SW-1:0] sum;
  logic signed [AW-1:0] acc, total;
  logic signed [INTERNAL_BITS-1:0] clip;
  state_t state, nxt;
  assign f_ext = {if_in, f_tap};
  assign w_ext = {w_in, w_tap};
  // feature and weight tap lines shift independently toward tap 0
  always_ff @(posedge clk) begin
    if (rst) begin
      f_tap <= '0;
      w_tap <= '0;
    end else begin
      if (if_w) f_tap <= f_ext[TAPS:1];
      if (w_w) w_tap <= w_ext[TAPS:1];
    end
  end
  // stage-1 term tag travelling alongside the registered products
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      v1 <= mac_en;
      l1 <= mac_en & mac_last;
    end
  end
  pe_dot #(.DATA_BITS(DATA_BITS), .TAPS(TAPS)) u_dot (
    .clk(clk), .rst(rst), .en(mac_en), .f(f_tap), .w(w_tap), .sum(sum)
  );
  assign commit = v1 & ~acc_clr;
  assign total = acc + AW'(sum);
`ifdef PE_SATURATE_EN
  logic [AW-INTERNAL_BITS:0] top;
  assign top = total[AW-1:INTERNAL_BITS-1];
  assign ovr = ~((&top) | ~(|top));
  assign clip = ~ovr ? total[INTERNAL_BITS-1:0] :
                total[AW-1] ? {1'b1, {(INTERNAL_BITS-1){1'b0}}} : {1'b0, {(INTERNAL_BITS-1){1'b1}}};
`else
  assign ovr = 1'b0;
  assign clip = total[INTERNAL_BITS-1:0];
`endif
  // accumulate committed terms; a last term publishes the window and restarts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      result <= '0;
      out_valid <= 1'b0;
      ov <= 1'b0;
    end else begin
      out_valid <= commit & l1;
      if (acc_clr) begin
        acc <= '0;
        ov <= 1'b0;
      end else if (v1) begin
        acc <= l1 ? '0 : total;
        if (l1) begin
          result <= clip;
          ov <= ov | ovr;
        end
      end
    end
  end
  // window state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // a new term opens the window; abort or the closing commit ends it
  always_comb begin
    nxt = state;
    nxt = mac_en ? ACCUM : (acc_clr || (commit && l1)) ? IDLE : state;
  end
  assign busy = (state == ACCUM) | v1;
  assign ovf = ov;
endmodule

// File: tb/tb_pe_kmac.sv
// tb_pe_kmac: scoreboard bench for pe_kmac windows, timing, overflow, abort and reset flush
module tb_pe_kmac;
  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst, if_w, w_w, mac_en, mac_last, acc_clr;
  logic signed [15:0] if_in, w_in;
  logic signed [31:0] result;
  logic out_valid, busy, ovf;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int mf[3], mw[3];
  longint win = 0;
  exp_t q[$];
  exp_t e_mon;
`ifdef PE_SATURATE_EN
  localparam logic [31:0] BIG_RES = 32'h7FFF_FFFF;
  localparam logic BIG_OVF = 1'b1;
`else
  localparam logic [31:0] BIG_RES = 32'hC000_0000;
  localparam logic BIG_OVF = 1'b0;
`endif

  pe_kmac dut (
    .clk(clk), .rst(rst), .if_w(if_w), .w_w(w_w), .if_in(if_in), .w_in(w_in),
    .mac_en(mac_en), .mac_last(mac_last), .acc_clr(acc_clr),
    .result(result), .out_valid(out_valid), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // every strobe must match the oldest expected window result and its arrival cycle
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL strobe_unexpected: got result=%h at cycle %0d, required no strobe", result, cyc);
      end else begin
        e_mon = q.pop_front();
        if (result !== e_mon.val || cyc != e_mon.cyc) begin
          n_bad++;
          $display("FAIL scoreboard: got result=%h at cycle %0d, required %h at cycle %0d",
                   result, cyc, e_mon.val, e_mon.cyc);
        end
      end
    end
  end

  function automatic longint dot();
    longint s = 0;
    for (int i = 0; i < 3; i++) s += longint'(mf[i]) * longint'(mw[i]);
    return s;
  endfunction

  function automatic logic [31:0] clip(input longint v);
`ifdef PE_SATURATE_EN
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mf[i] = 0;
      mw[i] = 0;
    end
    win = 0;
    q.delete();
  endtask

  task automatic drive(input bit fw, input int fv, input bit ww, input int wv,
                       input bit en, input bit last, input bit clr);
    exp_t e;
    if_w = fw; if_in = 16'(fv); w_w = ww; w_in = 16'(wv);
    mac_en = en; mac_last = last; acc_clr = clr;
    if (clr) win = 0;
    if (en) begin
      win += dot();
      if (last) begin
        e.val = clip(win);
        e.cyc = cyc + 2;
        q.push_back(e);
        win = 0;
      end
    end
    if (fw) begin mf[0] = mf[1]; mf[1] = mf[2]; mf[2] = fv; end
    if (ww) begin mw[0] = mw[1]; mw[1] = mw[2]; mw[2] = wv; end
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load(input int f0, input int f1, input int f2, input int w0, input int w1, input int w2);
    drive(1, f0, 1, w0, 0, 0, 0);
    drive(1, f1, 1, w1, 0, 0, 0);
    drive(1, f2, 1, w2, 0, 0, 0);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; if_w = 0; w_w = 0; if_in = 0; w_in = 0; mac_en = 0; mac_last = 0; acc_clr = 0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    n_cmp += 4;
    if (result !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h, required 0", result); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
    drive(0, 0, 0, 0, 0, 1, 0);
    idle(3);
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL lone_last_busy: got %b, required 0", busy); end
  endtask

  task automatic test_single();
    load(4, 5, 6, 1, 2, 3);
    drive(0, 0, 0, 0, 1, 1, 0);
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_t1_valid: got %b, required 0", out_valid); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL single_t1_busy: got %b, required 1", busy); end
    idle(1);
    n_cmp += 2;
    if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_t2_valid: got %b, required 1", out_valid); end
    if (result !== 32'sd32) begin n_bad++; $display("FAIL single_result: got %0d, required 32", result); end
    idle(1);
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_t3_valid: got %b, required 0", out_valid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_t3_busy: got %b, required 0", busy); end
  endtask

  task automatic test_window();
    drive(0, 0, 0, 0, 1, 0, 0);
    load(1, 2, 3, -1, -3, -1);
    drive(0, 0, 0, 0, 1, 0, 0);
    load(1, 2, 3, 1, 2, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL window_busy_open: got %b, required 1", busy); end
    idle(3);
    n_cmp += 2;
    if (result !== 32'sd27) begin n_bad++; $display("FAIL window_result: got %0d, required 27", result); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL window_busy_after: got %b, required 0", busy); end
  endtask

  task automatic test_overflow();
    load(-32768, -32768, -32768, -32768, -32768, -32768);
    drive(0, 0, 0, 0, 1, 1, 0);
    idle(3);
    n_cmp += 2;
    if (result !== BIG_RES) begin n_bad++; $display("FAIL big_result: got %h, required %h", result, BIG_RES); end
    if (ovf !== BIG_OVF) begin n_bad++; $display("FAIL big_ovf: got %b, required %b", ovf, BIG_OVF); end
  endtask

  task automatic test_clear();
    load(1, 1, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp += 2;
    if (ovf !== 1'b0) begin n_bad++; $display("FAIL clear_ovf: got %b, required 0", ovf); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL clear_busy: got %b, required 0", busy); end
    load(1, 2, 0, 1, 3, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    idle(3);
    n_cmp++;
    if (result !== 32'sd7) begin n_bad++; $display("FAIL clear_result: got %0d, required 7", result); end
  endtask

  task automatic test_rst_flush();
    load(2, 2, 2, 3, 3, 3);
    drive(0, 0, 0, 0, 1, 1, 0);
    rst_pulse();
    n_cmp += 3;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b, required 0", out_valid); end
    if (result !== 32'd0) begin n_bad++; $display("FAIL flush_result: got %h, required 0", result); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b, required 0", busy); end
    idle(3);
    repeat (3) drive(0, 0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    idle(3);
    n_cmp++;
    if (result !== 32'd0) begin n_bad++; $display("FAIL flush_ftaps: got %0d, required 0", result); end
    load(2, 2, 2, 3, 3, 3);
    rst_pulse();
    repeat (3) drive(1, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    idle(3);
    n_cmp++;
    if (result !== 32'd0) begin n_bad++; $display("FAIL flush_wtaps: got %0d, required 0", result); end
  endtask

  task automatic test_back_to_back();
    load(4, 5, 6, 1, 2, 3);
    drive(1, 10, 0, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    idle(4);
    n_cmp++;
    if (result !== 32'sd28) begin n_bad++; $display("FAIL b2b_last_result: got %0d, required 28", result); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_window();
    test_overflow();
    test_clear();
    test_rst_flush();
    test_back_to_back();
    n_cmp++;
    if (q.size() != 0) begin n_bad++; $display("FAIL missing_strobes: got %0d pending, required 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
